wb_ram_arbiter: RTL and testbench

//   Shares the single Wishbone RAM port between two bus masters:
//     - m0: video_in frame writer
//     - m1: video_out frame reader

---
 rtl/wb_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM slave between two video DMA masters.
// state    | meaning
// S_IDLE   | no owner, slave side quiet, arbitrating
// S_BUSY   | owner's cycle forwarded to slave, watchdog running
// S_ERR    | one-cycle ERR to owner after slave stall
// S_REL    | one-cycle dead cycle before next arbitration
module wb_ram_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [31:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [31:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic        s_CYC_O,
    output logic        s_STB_O,
    output logic        s_WE_O,
    output logic [3:0]  s_SEL_O,
    output logic [31:0] s_ADR_O,
    output logic [31:0] s_DAT_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK_I,
    output logic [1:0]  grant,
    output logic [7:0]  timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic          owner, owner_nx;     // 0 = m0, 1 = m1; meaningless in S_IDLE
    logic          last, last_nx;
    logic [TW-1:0] wdog, wdog_nx;
    logic [7:0]    tcnt_nx;

    logic req0, req1, own_cyc, own_stb;

    assign req0    = m0_CYC_I & m0_STB_I;
    assign req1    = m1_CYC_I & m1_STB_I;
    assign own_cyc = owner ? m1_CYC_I : m0_CYC_I;
    assign own_stb = owner ? m1_STB_I : m0_STB_I;

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            wdog        <= '0;
            timeout_cnt <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last        <= last_nx;
            wdog        <= wdog_nx;
            timeout_cnt <= tcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        wdog_nx  = '0;
        tcnt_nx  = timeout_cnt;
        case (state)
            S_IDLE: begin
                if (req0 && req1) begin
                    owner_nx = ~last;
                    state_nx = S_BUSY;
                end else if (req0) begin
                    owner_nx = 1'b0;
                    state_nx = S_BUSY;
                end else if (req1) begin
                    owner_nx = 1'b1;
                    state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!own_cyc) begin
                    last_nx  = owner;
                    state_nx = S_REL;
                end else if (own_stb && !s_ACK_I) begin
                    if (wdog == TW'(TIMEOUT - 1)) begin
                        state_nx = S_ERR;
                        if (timeout_cnt != 8'hFF)
                            tcnt_nx = timeout_cnt + 8'd1;
                    end else begin
                        wdog_nx = wdog + 1'b1;
                    end
                end
            end
            S_ERR: begin
                last_nx  = owner;
                state_nx = S_REL;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        grant    = '0;
        s_CYC_O  = 1'b0;
        s_STB_O  = 1'b0;
        s_WE_O   = 1'b0;
        s_SEL_O  = '0;
        s_ADR_O  = '0;
        s_DAT_O  = '0;
        m0_ACK_O = 1'b0;
        m1_ACK_O = 1'b0;
        m0_ERR_O = 1'b0;
        m1_ERR_O = 1'b0;
        case (state)
            S_BUSY: begin
                grant   = owner ? 2'b10 : 2'b01;
                s_CYC_O = own_cyc;
                s_STB_O = own_stb;
                s_WE_O  = owner ? m1_WE_I  : m0_WE_I;
                s_SEL_O = owner ? m1_SEL_I : m0_SEL_I;
                s_ADR_O = owner ? m1_ADR_I : m0_ADR_I;
                s_DAT_O = owner ? m1_DAT_I : m0_DAT_I;
                if (owner) m1_ACK_O = s_ACK_I;
                else       m0_ACK_O = s_ACK_I;
            end
            S_ERR: begin
                grant = owner ? 2'b10 : 2'b01;
                if (owner) m1_ERR_O = 1'b1;
                else       m0_ERR_O = 1'b1;
            end
            default: ;
        endcase
    end

    assign m0_DAT_O = s_DAT_I;
    assign m1_DAT_O = s_DAT_I;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed scenarios plus a randomized two-master run
// checked against a memory/fairness reference model.
module tb_wb_ram_arbiter;

    logic        clk = 1'b0;
    logic        RST;
    logic        m0_CYC_I, m0_STB_I, m0_WE_I;
    logic [3:0]  m0_SEL_I;
    logic [31:0] m0_ADR_I, m0_DAT_I, m0_DAT_O;
    logic        m0_ACK_O, m0_ERR_O;
    logic        m1_CYC_I, m1_STB_I, m1_WE_I;
    logic [3:0]  m1_SEL_I;
    logic [31:0] m1_ADR_I, m1_DAT_I, m1_DAT_O;
    logic        m1_ACK_O, m1_ERR_O;
    logic        s_CYC_O, s_STB_O, s_WE_O;
    logic [3:0]  s_SEL_O;
    logic [31:0] s_ADR_O, s_DAT_O, s_DAT_I;
    logic        s_ACK_I;
    logic [1:0]  grant;
    logic [7:0]  timeout_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // randomized-run master state and reference memories
    logic        req_q[2];
    logic        we_q[2];
    logic [31:0] adr_q[2];
    logic [31:0] dat_q[2];
    logic        acked_q[2];
    logic [31:0] ref_mem[16];
    logic [31:0] slv_mem[16];

    wb_ram_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .RST(RST),
        .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
        .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O),
        .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
        .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
        .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O),
        .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
        .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I),
        .grant(grant), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // inputs change 2 time units after the rising edge, checks follow 1 unit later
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_CYC_I = 0; m0_STB_I = 0; m0_WE_I = 0; m0_SEL_I = '0; m0_ADR_I = '0; m0_DAT_I = '0;
        m1_CYC_I = 0; m1_STB_I = 0; m1_WE_I = 0; m1_SEL_I = '0; m1_ADR_I = '0; m1_DAT_I = '0;
        s_ACK_I = 0; s_DAT_I = '0;
    endtask

    task automatic settle_idle();
        idle_inputs();
        next(); next(); next();
    endtask

    task automatic do_reset();
        RST = 1;
        idle_inputs();
        next(); next();
        RST = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        idle_inputs();
        m0_CYC_I = 1; m0_STB_I = 1; m1_CYC_I = 1; m1_STB_I = 1; s_ACK_I = 1;
        next(); next();
        #1;
        n_checks++;
        if ({grant, s_CYC_O, s_STB_O, s_WE_O, s_SEL_O, s_ADR_O, s_DAT_O,
             m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O, timeout_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: grant=%b s_cyc=%b ack=%b%b err=%b%b tcnt=%0d, required all zero",
                     grant, s_CYC_O, m1_ACK_O, m0_ACK_O, m1_ERR_O, m0_ERR_O, timeout_cnt);
        end
        RST = 0;
        settle_idle();
    endtask

    task automatic test_single_read();
        m1_CYC_I = 1; m1_STB_I = 1; m1_WE_I = 0; m1_SEL_I = 4'hF; m1_ADR_I = 32'h100;
        #1;
        n_checks++;
        if (s_CYC_O !== 1'b0 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL read_latency0: s_cyc=%b grant=%b, required 0 and 00", s_CYC_O, grant);
        end
        next(); #1;
        n_checks++;
        if (s_ADR_O !== 32'h100 || s_CYC_O !== 1'b1 || s_STB_O !== 1'b1 || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL read_forward: adr=%h cyc=%b stb=%b grant=%b, required 100 1 1 10",
                     s_ADR_O, s_CYC_O, s_STB_O, grant);
        end
        next();
        next();
        s_ACK_I = 1; s_DAT_I = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (m1_ACK_O !== 1'b1 || m1_DAT_O !== 32'hDEADBEEF || m0_ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack: m1_ack=%b m1_dat=%h m0_ack=%b, required 1 deadbeef 0",
                     m1_ACK_O, m1_DAT_O, m0_ACK_O);
        end
        settle_idle();
    endtask

    task automatic test_tie_after_reset();
        int gap;
        do_reset();
        m0_CYC_I = 1; m0_STB_I = 1; m0_WE_I = 1; m0_SEL_I = 4'hF; m0_ADR_I = 32'h10; m0_DAT_I = 32'h1234;
        m1_CYC_I = 1; m1_STB_I = 1; m1_WE_I = 0; m1_SEL_I = 4'hF; m1_ADR_I = 32'h20;
        next();
        s_ACK_I = 1;
        #1;
        n_checks++;
        if (grant !== 2'b01 || m0_ACK_O !== 1'b1 || m1_ACK_O !== 1'b0 || s_ADR_O !== 32'h10) begin
            n_fail++;
            $display("FAIL tie_first: grant=%b m0_ack=%b m1_ack=%b adr=%h, required 01 1 0 10",
                     grant, m0_ACK_O, m1_ACK_O, s_ADR_O);
        end
        next();
        m0_CYC_I = 0; m0_STB_I = 0; s_ACK_I = 0;
        #1;
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            if (s_CYC_O) break;
            gap++;
            next(); #1;
        end
        // owner drops CYC (1), RELEASE (1), IDLE arbitration (1)
        n_checks++;
        if (gap !== 3 || grant !== 2'b10) begin
            n_fail++;
            $display("FAIL tie_handover: gap=%0d grant=%b, required 3 and 10", gap, grant);
        end
        s_ACK_I = 1;
        #1;
        n_checks++;
        if (m1_ACK_O !== 1'b1 || m0_ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second_ack: m1_ack=%b m0_ack=%b, required 1 0", m1_ACK_O, m0_ACK_O);
        end
        next();
        settle_idle();
    endtask

    task automatic drive_masters();
        m0_CYC_I = req_q[0]; m0_STB_I = req_q[0]; m0_WE_I = we_q[0]; m0_SEL_I = 4'hF;
        m0_ADR_I = adr_q[0]; m0_DAT_I = dat_q[0];
        m1_CYC_I = req_q[1]; m1_STB_I = req_q[1]; m1_WE_I = we_q[1]; m1_SEL_I = 4'hF;
        m1_ADR_I = adr_q[1]; m1_DAT_I = dat_q[1];
    endtask

    task automatic test_back_to_back();
        int cnt[2];
        int wt, cycles, idx, bad_data, bad_route, bad_order;
        logic [1:0] cur_g, prev_owner_g;
        logic a[2];
        logic [31:0] rd;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            req_q[k] = 0; we_q[k] = 0; adr_q[k] = '0; dat_q[k] = '0; acked_q[k] = 0; cnt[k] = 0;
        end
        wt = 0; cycles = 0; bad_data = 0; bad_route = 0; bad_order = 0;
        cur_g = 2'b00; prev_owner_g = 2'b00;
        while (cycles < 2000 && cnt[0] + cnt[1] < 40) begin
            next();
            cycles++;
            for (int k = 0; k < 2; k++) begin
                if (acked_q[k]) begin
                    req_q[k] = 0;
                end else if (!req_q[k]) begin
                    req_q[k] = 1;
                    we_q[k]  = 1'($urandom_range(0, 1));
                    adr_q[k] = 32'($urandom_range(0, 15)) << 2;
                    dat_q[k] = $urandom;
                end
            end
            drive_masters();
            #1;
            if (s_CYC_O && s_STB_O) begin
                if (wt == 0) begin
                    idx = int'(s_ADR_O[5:2]);
                    if (s_WE_O) slv_mem[idx] = s_DAT_O;
                    s_DAT_I = slv_mem[idx];
                    s_ACK_I = 1;
                    wt = $urandom_range(0, 2);
                end else begin
                    s_ACK_I = 0;
                    s_DAT_I = $urandom;
                    wt--;
                end
            end else begin
                s_ACK_I = 0;
            end
            #1;
            a[0] = m0_ACK_O;
            a[1] = m1_ACK_O;
            if (a[0] && a[1]) bad_route++;
            if (grant != 2'b00 && cur_g == 2'b00) begin
                if (prev_owner_g != 2'b00 && grant == prev_owner_g) bad_order++;
                prev_owner_g = grant;
            end
            cur_g = grant;
            for (int k = 0; k < 2; k++) begin
                if (a[k]) begin
                    if (!req_q[k]) bad_route++;
                    idx = int'(adr_q[k][5:2]);
                    rd = (k == 0) ? m0_DAT_O : m1_DAT_O;
                    if (we_q[k]) ref_mem[idx] = dat_q[k];
                    else if (rd !== ref_mem[idx]) bad_data++;
                    cnt[k]++;
                end
                acked_q[k] = a[k];
            end
        end
        n_checks++;
        if (cnt[0] + cnt[1] < 40) begin
            n_fail++;
            $display("FAIL b2b_progress: %0d transfers in %0d cycles, required 40", cnt[0] + cnt[1], cycles);
        end
        n_checks++;
        if (bad_data != 0) begin
            n_fail++;
            $display("FAIL b2b_read_data: %0d reads differ from reference memory, required 0", bad_data);
        end
        n_checks++;
        if (bad_route != 0) begin
            n_fail++;
            $display("FAIL b2b_ack_routing: %0d misrouted acks, required 0", bad_route);
        end
        n_checks++;
        if (bad_order != 0) begin
            n_fail++;
            $display("FAIL b2b_round_robin: %0d repeated owners, required 0", bad_order);
        end
        n_checks++;
        if (cnt[0] - cnt[1] > 1 || cnt[1] - cnt[0] > 1) begin
            n_fail++;
            $display("FAIL b2b_fairness: m0=%0d m1=%0d acks, required within 1", cnt[0], cnt[1]);
        end
        settle_idle();
    endtask

    task automatic test_burst();
        int acks;
        logic early;
        logic found;
        acks = 0; early = 0; found = 0;
        m0_CYC_I = 1; m0_STB_I = 1; m0_WE_I = 1; m0_SEL_I = 4'hF; m0_ADR_I = 32'h400;
        for (int i = 0; i < 40 && acks < 16; i++) begin
            next();
            if (acks >= 1) begin
                m1_CYC_I = 1; m1_STB_I = 1; m1_ADR_I = 32'h800;
            end
            m0_ADR_I = 32'h400 + 32'(acks * 4);
            m0_DAT_I = $urandom;
            #1;
            s_ACK_I = s_CYC_O & s_STB_O;
            #1;
            if (grant[1] || m1_ACK_O) early = 1;
            if (m0_ACK_O) acks++;
        end
        n_checks++;
        if (acks !== 16) begin
            n_fail++;
            $display("FAIL burst_beats: %0d m0 acks, required 16", acks);
        end
        next();
        m0_CYC_I = 0; m0_STB_I = 0; s_ACK_I = 0;
        #1;
        if (grant[1]) early = 1;
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL burst_no_preempt: m1 granted during m0 burst, required no grant");
        end
        for (int i = 0; i < 8; i++) begin
            next(); #1;
            if (grant == 2'b10) begin
                found = 1;
                break;
            end
        end
        s_ACK_I = 1;
        #1;
        n_checks++;
        if (!found || m1_ACK_O !== 1'b1 || m0_ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_m1_after: found=%b m1_ack=%b m0_ack=%b, required 1 1 0",
                     found, m1_ACK_O, m0_ACK_O);
        end
        next();
        settle_idle();
    endtask

    task automatic test_timeout();
        logic err_seen;
        logic g_bad;
        do_reset();
        err_seen = 0; g_bad = 0;
        m0_CYC_I = 1; m0_STB_I = 1; m0_WE_I = 0; m0_SEL_I = 4'hF; m0_ADR_I = 32'h40;
        // two stalls of TIMEOUT-1 cycles each ended by an ACK must not fire
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 15; i++) begin
                next();
                s_ACK_I = 0;
                #1;
                if (m0_ERR_O || m1_ERR_O) err_seen = 1;
                if (grant != 2'b01) g_bad = 1;
            end
            next();
            s_ACK_I = 1;
            #1;
            if (m0_ERR_O || m1_ERR_O || !m0_ACK_O) err_seen = 1;
        end
        m1_CYC_I = 1; m1_STB_I = 1; m1_ADR_I = 32'h80;
        for (int i = 0; i < 16; i++) begin
            next();
            s_ACK_I = 0;
            #1;
            if (m0_ERR_O || m1_ERR_O) err_seen = 1;
            if (grant != 2'b01) g_bad = 1;
        end
        n_checks++;
        if (err_seen || g_bad) begin
            n_fail++;
            $display("FAIL wdog_before_fire: early_err_or_noack=%b grant_lost=%b, required 0 0", err_seen, g_bad);
        end
        next();
        s_ACK_I = 1;
        #1;
        n_checks++;
        if (m0_ERR_O !== 1'b1 || m1_ERR_O !== 1'b0 || s_CYC_O !== 1'b0 || s_STB_O !== 1'b0 ||
            m0_ACK_O !== 1'b0 || grant !== 2'b01) begin
            n_fail++;
            $display("FAIL wdog_err_cycle: m0_err=%b m1_err=%b s_cyc=%b s_stb=%b m0_ack=%b grant=%b, required 1 0 0 0 0 01",
                     m0_ERR_O, m1_ERR_O, s_CYC_O, s_STB_O, m0_ACK_O, grant);
        end
        next();
        m0_CYC_I = 0; m0_STB_I = 0; s_ACK_I = 0;
        #1;
        n_checks++;
        if (m0_ERR_O !== 1'b0 || grant !== 2'b00 || timeout_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL wdog_release: m0_err=%b grant=%b tcnt=%0d, required 0 00 1",
                     m0_ERR_O, grant, timeout_cnt);
        end
        next();
        next(); #1;
        n_checks++;
        if (grant !== 2'b10 || s_CYC_O !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_next_owner: grant=%b s_cyc=%b, required 10 1", grant, s_CYC_O);
        end
        s_ACK_I = 1;
        next();
        settle_idle();
    endtask

    task automatic test_reset_mid_burst();
        m1_CYC_I = 1; m1_STB_I = 1; m1_WE_I = 1; m1_SEL_I = 4'h3; m1_ADR_I = 32'hC0; m1_DAT_I = 32'h55AA;
        s_ACK_I = 1;
        for (int i = 0; i < 4; i++) next();
        RST = 1;
        #1;
        next();
        RST = 0;
        #1;
        n_checks++;
        if ({grant, s_CYC_O, s_STB_O, s_WE_O, s_SEL_O, s_ADR_O, s_DAT_O,
             m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O, timeout_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: grant=%b s_cyc=%b adr=%h ack=%b%b err=%b%b tcnt=%0d, required all zero",
                     grant, s_CYC_O, s_ADR_O, m1_ACK_O, m0_ACK_O, m1_ERR_O, m0_ERR_O, timeout_cnt);
        end
        m0_CYC_I = 1; m0_STB_I = 1; m0_ADR_I = 32'hE0;
        s_ACK_I = 0;
        next(); #1;
        n_checks++;
        if (grant !== 2'b01 || s_ADR_O !== 32'hE0) begin
            n_fail++;
            $display("FAIL midreset_tie: grant=%b adr=%h, required 01 e0", grant, s_ADR_O);
        end
        settle_idle();
    endtask

    initial begin
        RST = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_tie_after_reset();
        test_back_to_back();
        test_burst();
        test_timeout();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
